// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for the core's load/store port.
// Serves one word access at a time with byte enables and a fixed number of
// wait states between accept and the one-cycle response strobe.
module data_mem_responder #(
  parameter int DEPTH    = 64,
  parameter int WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_W  = 30'(DEPTH);
  localparam logic [3:0]  CNT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_mem [DEPTH];

  logic          w_accept;
  logic          w_cnt_done;
  logic          w_enter_resp;
  logic          w_we;
  logic [31:0]   w_addr;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic          w_fault;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rdata_nxt;

  // Accept only in IDLE and never while reset is asserted.
  assign w_accept   = rst && (r_state == IDLE) && req;
  assign w_cnt_done = (r_state == WAIT) && (r_cnt == 4'd0);
  // With zero wait states RESP is entered on the accept edge itself.
  assign w_enter_resp = rst && ((w_accept && (WAIT_CYC == 0)) || w_cnt_done);

  // On the accept edge the request lives on the inputs; afterwards in registers.
  assign w_we    = (r_state == IDLE) ? we    : r_we;
  assign w_addr  = (r_state == IDLE) ? addr  : r_addr;
  assign w_be    = (r_state == IDLE) ? be    : r_be;
  assign w_wdata = (r_state == IDLE) ? wdata : r_wdata;

  assign w_fault     = (w_addr[1:0] != 2'b00) || (w_addr[31:2] >= DEPTH_W);
  assign w_idx       = w_addr[2 +: AW];
  assign w_rdata_nxt = (w_fault || w_we) ? 32'd0 : r_mem[w_idx];

  // Byte-enabled store on the edge entering RESP; array is not reset.
  always_ff @(posedge clk) begin
    if (w_enter_resp && w_we && !w_fault) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      ready   <= 1'b1;
      rvalid  <= 1'b0;
      rdata   <= 32'd0;
      err     <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_be    <= 4'd0;
      r_wdata <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req) begin
            r_we    <= we;
            r_addr  <= addr;
            r_be    <= be;
            r_wdata <= wdata;
            ready   <= 1'b0;
            if (WAIT_CYC == 0) begin
              r_state <= RESP;
              rvalid  <= 1'b1;
              rdata   <= w_rdata_nxt;
              err     <= w_fault;
            end else begin
              r_state <= WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= RESP;
            rvalid  <= 1'b1;
            rdata   <= w_rdata_nxt;
            err     <= w_fault;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
          ready   <= 1'b1;
          rvalid  <= 1'b0;
          rdata   <= 32'd0;
          err     <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          ready   <= 1'b1;
          rvalid  <= 1'b0;
          rdata   <= 32'd0;
          err     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a response scoreboard.
module tb_data_mem_responder;

  localparam int DEPTH = 64;
  localparam int WC    = 2;

  logic        clk = 1'b0;
  logic        rst, req, req0, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        ready, rvalid, err;
  logic [31:0] rdata;
  logic        ready0, rvalid0, err0;
  logic [31:0] rdata0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYC(WC)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be),
    .wdata(wdata), .ready(ready), .rvalid(rvalid), .rdata(rdata), .err(err));

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYC(0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we), .addr(addr), .be(be),
    .wdata(wdata), .ready(ready0), .rvalid(rvalid0), .rdata(rdata0), .err(err0));

  int          tests = 0;
  int          fails = 0;
  int          rv_cnt = 0;
  logic [32:0] sb_q[$];
  logic [31:0] mdl [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every response must match the oldest expectation.
  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      logic [32:0] e;
      rv_cnt++;
      chk("rvalid_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_err", 32'(err), 32'(e[32]));
        chk("sb_rdata", rdata, e[31:0]);
      end
    end
  end

  // Predict response and model memory update for an access about to be accepted.
  task automatic predict(input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d);
    logic f;
    logic [31:0] exp;
    f = (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
    exp = 32'd0;
    if (!f && !w) exp = mdl[a[2 +: 6]];
    if (!f && w)
      for (int i = 0; i < 4; i++) if (b[i]) mdl[a[2 +: 6]][8*i +: 8] = d[8*i +: 8];
    sb_q.push_back({f, exp});
  endtask

  task automatic access(input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, input string tag);
    int n;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    n = 0;
    while (ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_ready_to"}, 32'(ready), 32'd1);
    predict(w, a, b, d);
    @(posedge clk); #1;
    req = 1'b0; we = ~w; addr = 32'hFFFF_FFFF; be = ~b; wdata = ~d;
    n = 0;
    do begin @(negedge clk); n++; end while (rvalid !== 1'b1 && n < 20);
    chk({tag, "_latency"}, 32'(n), 32'(WC + 1));
    @(negedge clk);
    chk({tag, "_rvalid_drop"}, 32'(rvalid), 32'd0);
    chk({tag, "_ready_back"}, 32'(ready), 32'd1);
  endtask

  initial begin
    int last, gap_bad, rv0, acc, n;
    rst = 1'b0; req = 1'b1; req0 = 1'b0; we = 1'b1; addr = 32'h0; be = 4'hF;
    wdata = 32'h0;

    // Reset for two cycles with req asserted: reset wins.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b1; req = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_no_rvalid", 32'(rv_cnt), 32'd0);

    // Store then load.
    access(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, "st10");
    access(1'b0, 32'h10, 4'h0, 32'h0, "ld10");

    // Byte enables.
    access(1'b1, 32'h4, 4'hF, 32'h1122_3344, "st4full");
    access(1'b1, 32'h4, 4'b0101, 32'hAABB_CCDD, "st4be");
    access(1'b0, 32'h4, 4'h0, 32'h0, "ld4");
    access(1'b1, 32'h4, 4'b0000, 32'hFFFF_FFFF, "st4noop");
    access(1'b0, 32'h4, 4'h0, 32'h0, "ld4b");

    // Faults.
    access(1'b0, 32'h6, 4'h0, 32'h0, "ld_misal");
    access(1'b1, 32'h4 * DEPTH - 4, 4'hF, 32'hCAFE_F00D, "st_last");
    access(1'b1, 32'h4 * DEPTH, 4'hF, 32'h1234_5678, "st_oob");
    access(1'b0, 32'h4 * DEPTH - 4, 4'h0, 32'h0, "ld_last");

    // Back-to-back with req held high.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h10; be = 4'h0;
    last = -1; gap_bad = 0; acc = 0; rv0 = rv_cnt;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      if (ready === 1'b1) begin
        if (last >= 0 && (i - last) != WC + 2) gap_bad++;
        last = i; acc++;
        predict(1'b0, 32'h10, 4'h0, 32'h0);
      end
    end
    @(posedge clk); #1; req = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("b2b_accepts", 32'(acc), 32'd3);
    chk("b2b_gap", 32'(gap_bad), 32'd0);
    chk("b2b_rvalids", 32'(rv_cnt - rv0), 32'(acc));

    // Reset in the first WAIT cycle aborts a store.
    access(1'b1, 32'h8, 4'hF, 32'h0102_0304, "st8");
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h8; be = 4'hF; wdata = 32'h5A5A_5A5A;
    chk("abort_ready", 32'(ready), 32'd1);
    @(posedge clk); #1; req = 1'b0;
    rv0 = rv_cnt;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_no_rvalid", 32'(rv_cnt - rv0), 32'd0);
    chk("abort_ready_after", 32'(ready), 32'd1);
    access(1'b0, 32'h8, 4'h0, 32'h0, "ld8");

    // Zero wait states: response in the cycle after accept.
    @(negedge clk);
    req0 = 1'b1; we = 1'b1; addr = 32'h20; be = 4'hF; wdata = 32'h0BAD_F00D;
    chk("w0_ready", 32'(ready0), 32'd1);
    @(posedge clk); #1; req0 = 1'b0;
    @(negedge clk);
    chk("w0_st_rvalid", 32'(rvalid0), 32'd1);
    chk("w0_st_err", 32'(err0), 32'd0);
    chk("w0_st_rdata", rdata0, 32'd0);
    @(negedge clk);
    chk("w0_rvalid_drop", 32'(rvalid0), 32'd0);
    chk("w0_ready_back", 32'(ready0), 32'd1);
    req0 = 1'b1; we = 1'b0; addr = 32'h20;
    @(posedge clk); #1; req0 = 1'b0; addr = 32'h0;
    @(negedge clk);
    chk("w0_ld_rvalid", 32'(rvalid0), 32'd1);
    chk("w0_ld_rdata", rdata0, 32'h0BAD_F00D);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
